bram_port_arbiter: RTL
======================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 8, word width in bits.
REQ-002 SHALL have parameter Depth, default 1024, number of words in the attached BRAM port.
REQ-003 SHALL have parameter AddrWidth, default $clog2(Depth+1), address width.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i (in, 1) is the sole clock, rising edge; rst_ni (in, 1) is the async reset, active low.
REQ-005 SHALL have port rN_valid_i (N=0,1), in, 1: requester N presents a transaction.
REQ-006 SHALL have port rN_ready_o, out, 1: transaction of requester N accepted this cycle.
REQ-007 SHALL have port rN_we_i, in, 1: 1 = write, 0 = read.
REQ-008 SHALL have port rN_lock_i, in, 1: retain grant after this beat.
REQ-009 SHALL have port rN_addr_i, in, AddrWidth: word address.
REQ-010 SHALL have port rN_data_i, in, DataWidth: write data.
REQ-011 SHALL have port rN_rvalid_o, out, 1: read data valid for requester N.
REQ-012 SHALL have port rN_rdata_o, out, DataWidth: read data.
REQ-013 SHALL have ports mem_write_en_o (out, 1), mem_addr_o (out, AddrWidth) and mem_data_o (out, DataWidth) driving one BRAM port.
REQ-014 SHALL have port mem_data_i, in, DataWidth: BRAM registered read data, 1-cycle latency.
REQ-015 SHALL have port err_o, out, 1: out-of-range pulse (see Configuration).

Function
REQ-016 SHALL accept at most one transaction per cycle; accept = rN_valid_i & rN_ready_o.
REQ-017 SHALL compute rN_ready_o combinationally from valids, state and priority pointer; ready never asserts without the matching valid.
REQ-018 SHALL implement FSM states ARB and LOCKED(N).
REQ-019 SHALL arbitrate round-robin in ARB: if both are valid, grant the requester not granted last; if one is valid, grant it.
REQ-020 SHALL, in LOCKED(N), grant only requester N; the other requester's ready stays 0 even if N is idle.
REQ-021 SHALL transition: accept by N with rN_lock_i=1 -> LOCKED(N); accept by N with lock=0 -> ARB; no accept -> stay.
REQ-022 SHALL update the last-grant pointer on every accept, including accepts made in LOCKED.
REQ-023 SHALL, on an accept, drive mem_addr_o = rN_addr_i, mem_data_o = rN_data_i and mem_write_en_o = rN_we_i in the same cycle.
REQ-024 SHALL, with no accept, drive mem_write_en_o=0; mem_addr_o and mem_data_o hold their last values.
REQ-025 SHALL, for an accepted read in cycle T, assert rN_rvalid_o for exactly cycle T+1 with rN_rdata_o = mem_data_i.
REQ-026 SHALL NOT assert rvalid for writes; write-through data returned by the BRAM is ignored.
REQ-027 SHALL hold rN_rdata_o at its last value when rvalid is low.
REQ-028 SHALL not allow backpressure on responses; requesters must sample rvalid.
REQ-029 SHALL resolve back-to-back reads from alternating requesters with no bubble, each response routed by a registered requester tag.

Reset
REQ-030 SHALL, on rst_ni low (asynchronously): state=ARB; pointer set so requester 0 wins first tie; rvalid 0/0; rdata 0; err_o 0; pending read tag cleared.
REQ-031 SHALL drop a read accepted in the cycle reset asserts; no rvalid after release.
REQ-032 SHALL keep all readies 0 while rst_ni is low.

Configuration
REQ-033 SHALL, with macro BRAM_ARB_BOUNDS_CHECK_EN defined, treat an accepted addr >= Depth as follows: accepted normally, mem_write_en_o forced 0, err_o pulsed 1 in cycle T+1, and for reads rvalid asserted at T+1 with rdata 0.
REQ-034 SHALL, without BRAM_ARB_BOUNDS_CHECK_EN, forward all addresses unchanged and tie err_o to 0.

Verification
REQ-035 SHALL cover: both requesters issue reads continuously from addr 0..7 -> accepts alternate r0,r1,r0,...; each rvalid is 1 cycle after its accept with the correct word.
REQ-036 SHALL cover: r0 writes 0xA5 to addr 5 at T; r1 reads addr 5 at T+1 -> r1_rvalid_o=1 at T+2 with 0xA5; r0_rvalid_o never asserts.
REQ-037 SHALL cover: r0 issues 3 beats with lock=1 then 1 beat with lock=0 while r1_valid_i is held 1 -> r1_ready_o=0 for all 4 beats, then r1 granted on the next cycle.
REQ-038 SHALL cover: with BRAM_ARB_BOUNDS_CHECK_EN, r1 reads addr 1024 -> mem_write_en_o=0, err_o=1 and r1_rvalid_o=1 with rdata 0x00 next cycle; without the macro, err_o stays 0.
REQ-039 SHALL cover: rst_ni pulsed low in the cycle a read is accepted -> no rvalid after release; first tie after reset goes to r0.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two requesters share one BRAM port.
// Round-robin grant with an optional per-beat lock. Read responses are routed
// one cycle after accept using a registered requester tag.
// Optional feature macro: BRAM_ARB_BOUNDS_CHECK_EN -- accesses with
// addr >= Depth are accepted, but writes are suppressed, reads return 0, and
// err_o pulses in the response cycle.
//
// state   | meaning
// ARB     | round-robin between both requesters
// LOCKED0 | only requester 0 may be granted
// LOCKED1 | only requester 1 may be granted
module bram_port_arbiter #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Depth     = 1024,
    parameter int unsigned AddrWidth = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 r0_valid_i,
    output logic                 r0_ready_o,
    input  logic                 r0_we_i,
    input  logic                 r0_lock_i,
    input  logic [AddrWidth-1:0] r0_addr_i,
    input  logic [DataWidth-1:0] r0_data_i,
    output logic                 r0_rvalid_o,
    output logic [DataWidth-1:0] r0_rdata_o,
    input  logic                 r1_valid_i,
    output logic                 r1_ready_o,
    input  logic                 r1_we_i,
    input  logic                 r1_lock_i,
    input  logic [AddrWidth-1:0] r1_addr_i,
    input  logic [DataWidth-1:0] r1_data_i,
    output logic                 r1_rvalid_o,
    output logic [DataWidth-1:0] r1_rdata_o,
    output logic                 mem_write_en_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_data_o,
    input  logic [DataWidth-1:0] mem_data_i,
    output logic                 err_o
);

    typedef enum logic [1:0] {ARB = 2'd0, LOCKED0 = 2'd1, LOCKED1 = 2'd2} state_t;

    state_t state, state_next;
    // 1: requester 1 was granted last, so requester 0 wins the next tie
    logic last_grant;
    logic accept0, accept1, accept, sel, sel_we, sel_lock, oob;
    logic [AddrWidth-1:0] sel_addr, addr_q;
    logic [DataWidth-1:0] sel_data, data_q, resp_data, rdata0_q, rdata1_q;
    logic rd_pend, rd_tag, rd_oob;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ARB;
        else         state <= state_next;
    end

    // Next state: the accepted beat's lock bit decides whether the grant is held
    always_comb begin
        state_next = state;
        if (accept) begin
            if (sel_lock) state_next = sel ? LOCKED1 : LOCKED0;
            else          state_next = ARB;
        end
    end

    // Ready outputs; gated by reset so nothing is accepted while in reset
    always_comb begin
        r0_ready_o = 1'b0;
        r1_ready_o = 1'b0;
        if (rst_ni) begin
            case (state)
                ARB: begin
                    if (r0_valid_i && r1_valid_i) begin
                        r0_ready_o = last_grant;
                        r1_ready_o = ~last_grant;
                    end else begin
                        r0_ready_o = r0_valid_i;
                        r1_ready_o = r1_valid_i;
                    end
                end
                LOCKED0: r0_ready_o = r0_valid_i;
                LOCKED1: r1_ready_o = r1_valid_i;
                default: ;
            endcase
        end
    end

    assign accept0  = r0_valid_i & r0_ready_o;
    assign accept1  = r1_valid_i & r1_ready_o;
    assign accept   = accept0 | accept1;
    assign sel      = accept1;
    assign sel_we   = sel ? r1_we_i   : r0_we_i;
    assign sel_lock = sel ? r1_lock_i : r0_lock_i;
    assign sel_addr = sel ? r1_addr_i : r0_addr_i;
    assign sel_data = sel ? r1_data_i : r0_data_i;

`ifdef BRAM_ARB_BOUNDS_CHECK_EN
    logic err_q;

    assign oob = 32'(sel_addr) >= Depth;

    // One-cycle error pulse in the response cycle of an out-of-range beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= accept & oob;
    end

    assign err_o = err_q;
`else
    assign oob   = 1'b0;
    assign err_o = 1'b0;
`endif

    // BRAM port: pass-through on accept, otherwise hold the last address/data
    assign mem_write_en_o = accept & sel_we & ~oob;
    assign mem_addr_o     = accept ? sel_addr : addr_q;
    assign mem_data_o     = accept ? sel_data : data_q;

    // Grant pointer and held BRAM address/data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
        end else if (accept) begin
            last_grant <= sel;
            addr_q     <= sel_addr;
            data_q     <= sel_data;
        end
    end

    // Read tag pipeline: one outstanding response, due the cycle after accept
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
            rd_oob  <= 1'b0;
        end else begin
            rd_pend <= accept & ~sel_we;
            if (accept) begin
                rd_tag <= sel;
                rd_oob <= oob;
            end
        end
    end

    assign resp_data   = rd_oob ? '0 : mem_data_i;
    assign r0_rvalid_o = rd_pend & ~rd_tag;
    assign r1_rvalid_o = rd_pend & rd_tag;
    assign r0_rdata_o  = r0_rvalid_o ? resp_data : rdata0_q;
    assign r1_rdata_o  = r1_rvalid_o ? resp_data : rdata1_q;

    // Read data holds between responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (r0_rvalid_o) rdata0_q <= resp_data;
            if (r1_rvalid_o) rdata1_q <= resp_data;
        end
    end

endmodule
